// File: rtl/med_line_buf_ctrl.sv
// Line-buffer sequencer for the 3x3 median front end: drives two line-delay FIFOs
// and emits aligned top/mid/bot columns. Optional FIFO protocol check: MLB_ERR_CHECK_EN.
module med_line_buf_ctrl #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IMG_WIDTH  = 640,
    parameter int C_IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    output logic                    fifo_rst,
    output logic                    fifo0_wr_en,
    output logic [C_DATA_WIDTH-1:0] fifo0_din,
    output logic                    fifo0_rd_en,
    input  logic [C_DATA_WIDTH-1:0] fifo0_dout,
    input  logic                    fifo0_full,
    input  logic                    fifo0_empty,
    output logic                    fifo1_wr_en,
    output logic [C_DATA_WIDTH-1:0] fifo1_din,
    output logic                    fifo1_rd_en,
    input  logic [C_DATA_WIDTH-1:0] fifo1_dout,
    input  logic                    fifo1_full,
    input  logic                    fifo1_empty,
    output logic                    m_valid,
    output logic [C_DATA_WIDTH-1:0] m_top,
    output logic [C_DATA_WIDTH-1:0] m_mid,
    output logic [C_DATA_WIDTH-1:0] m_bot,
    output logic                    m_eol,
    output logic                    m_eof,
    output logic                    err
);

    localparam int CW = (C_IMG_WIDTH  > 1) ? $clog2(C_IMG_WIDTH)  : 1;
    localparam int RW = (C_IMG_HEIGHT > 1) ? $clog2(C_IMG_HEIGHT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL0,
        S_FILL1,
        S_RUN,
        S_CLEAR
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic                    m_valid_q, m_valid_d;
    logic [C_DATA_WIDTH-1:0] m_top_q, m_top_d;
    logic [C_DATA_WIDTH-1:0] m_mid_q, m_mid_d;
    logic [C_DATA_WIDTH-1:0] m_bot_q, m_bot_d;
    logic                    m_eol_q, m_eol_d;
    logic                    m_eof_q, m_eof_d;

    logic xfer;
    logic col_last;
    logic row_last;

    assign s_ready   = (state_q != S_CLEAR);
    assign xfer      = s_valid & s_ready;
    assign col_last  = (col_q == CW'(C_IMG_WIDTH - 1));
    assign row_last  = (row_q == RW'(C_IMG_HEIGHT - 1));
    assign fifo0_din = s_data;
    assign fifo1_din = fifo0_dout;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        fifo_rst    = 1'b0;
        fifo0_wr_en = 1'b0;
        fifo0_rd_en = 1'b0;
        fifo1_wr_en = 1'b0;
        fifo1_rd_en = 1'b0;
        m_valid_d   = 1'b0;
        m_top_d     = m_top_q;
        m_mid_d     = m_mid_q;
        m_bot_d     = m_bot_q;
        m_eol_d     = 1'b0;
        m_eof_d     = 1'b0;

        // raster position advance shared by every pixel-consuming state
        if (xfer && state_q != S_IDLE) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    fifo0_wr_en = 1'b1;
                    col_d       = CW'(1);
                    row_d       = '0;
                    state_d     = S_FILL0;
                end
            end
            S_FILL0: begin
                if (xfer) begin
                    fifo0_wr_en = 1'b1;
                    if (col_last) state_d = S_FILL1;
                end
            end
            S_FILL1: begin
                if (xfer) begin
                    fifo0_rd_en = 1'b1;
                    fifo0_wr_en = 1'b1;
                    fifo1_wr_en = 1'b1;
                    if (col_last) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    fifo0_rd_en = 1'b1;
                    fifo0_wr_en = 1'b1;
                    fifo1_rd_en = 1'b1;
                    fifo1_wr_en = 1'b1;
                    m_valid_d   = 1'b1;
                    m_bot_d     = s_data;
                    m_mid_d     = fifo0_dout;
                    m_top_d     = fifo1_dout;
                    m_eol_d     = col_last;
                    m_eof_d     = col_last & row_last;
                    if (col_last && row_last) state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                fifo_rst = 1'b1;
                col_d    = '0;
                row_d    = '0;
                state_d  = S_IDLE;
            end
            default: begin
                col_d   = '0;
                row_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_top_q   <= '0;
            m_mid_q   <= '0;
            m_bot_q   <= '0;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_top_q   <= m_top_d;
            m_mid_q   <= m_mid_d;
            m_bot_q   <= m_bot_d;
            m_eol_q   <= m_eol_d;
            m_eof_q   <= m_eof_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_top   = m_top_q;
    assign m_mid   = m_mid_q;
    assign m_bot   = m_bot_q;
    assign m_eol   = m_eol_q;
    assign m_eof   = m_eof_q;

`ifdef MLB_ERR_CHECK_EN
    logic err_q, err_d;

    // sticky: only rst_n clears it, fifo_rst does not
    always_comb begin
        err_d = err_q
              | (fifo0_wr_en & fifo0_full)
              | (fifo0_rd_en & fifo0_empty)
              | (fifo1_wr_en & fifo1_full)
              | (fifo1_rd_en & fifo1_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_flags;

    assign unused_flags = ^{fifo0_full, fifo0_empty, fifo1_full, fifo1_empty};
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_med_line_buf_ctrl.sv
// Bench for med_line_buf_ctrl: FIFO models, frame-level reference model
// and a queue scoreboard checked by an independent output monitor.
module tb_med_line_buf_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int NP = W * H;
    localparam int FD = 8;
`ifdef MLB_ERR_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          fifo_rst;
    logic          fifo0_wr_en, fifo0_rd_en;
    logic          fifo1_wr_en, fifo1_rd_en;
    logic [DW-1:0] fifo0_din, fifo1_din;
    logic [DW-1:0] fifo0_dout = '0;
    logic [DW-1:0] fifo1_dout = '0;
    logic          full0_r = 1'b0, full1_r = 1'b0;
    logic          fifo0_empty = 1'b1, fifo1_empty = 1'b1;
    logic          fifo0_full, fifo1_full;
    logic          force_full0 = 1'b0;
    logic          m_valid, m_eol, m_eof, err;
    logic [DW-1:0] m_top, m_mid, m_bot;

    int n_tests = 0;
    int n_fail  = 0;

    assign fifo0_full = full0_r | force_full0;
    assign fifo1_full = full1_r;

    always #5 clk = ~clk;

    med_line_buf_ctrl #(
        .C_DATA_WIDTH(DW),
        .C_IMG_WIDTH (W),
        .C_IMG_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .fifo_rst   (fifo_rst),
        .fifo0_wr_en(fifo0_wr_en),
        .fifo0_din  (fifo0_din),
        .fifo0_rd_en(fifo0_rd_en),
        .fifo0_dout (fifo0_dout),
        .fifo0_full (fifo0_full),
        .fifo0_empty(fifo0_empty),
        .fifo1_wr_en(fifo1_wr_en),
        .fifo1_din  (fifo1_din),
        .fifo1_rd_en(fifo1_rd_en),
        .fifo1_dout (fifo1_dout),
        .fifo1_full (fifo1_full),
        .fifo1_empty(fifo1_empty),
        .m_valid    (m_valid),
        .m_top      (m_top),
        .m_mid      (m_mid),
        .m_bot      (m_bot),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .err        (err)
    );

    // fall-through FIFO models; top level also resets them from ~rst_n
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    always @(posedge clk) begin
        logic [DW-1:0] d0, d1;
        logic w0, r0, w1, r1;
        d0 = fifo0_din;
        d1 = fifo1_din;
        w0 = fifo0_wr_en;
        r0 = fifo0_rd_en;
        w1 = fifo1_wr_en;
        r1 = fifo1_rd_en;
        if (!rst_n || fifo_rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (r0 && q0.size() != 0) void'(q0.pop_front());
            if (w0) q0.push_back(d0);
            if (r1 && q1.size() != 0) void'(q1.pop_front());
            if (w1) q1.push_back(d1);
        end
        fifo0_dout  <= (q0.size() != 0) ? q0[0] : '0;
        fifo1_dout  <= (q1.size() != 0) ? q1[0] : '0;
        full0_r     <= (q0.size() >= FD);
        full1_r     <= (q1.size() >= FD);
        fifo0_empty <= (q0.size() == 0);
        fifo1_empty <= (q1.size() == 0);
    end

    // reference model: frame stored as a flat raster, window read by index
    logic [DW-1:0] frame[NP];
    logic [3*DW+1:0] exp_q[$];
    int k = 0;

    task automatic model_push(input logic [DW-1:0] d);
        int row, col;
        row = k / W;
        col = k % W;
        frame[k] = d;
        if (row >= 2) begin
            exp_q.push_back({frame[k-2*W], frame[k-W], d,
                             (col == W-1), (k == NP-1)});
        end
        k = (k == NP-1) ? 0 : k + 1;
    endtask

    always @(negedge clk) begin
        logic [3*DW+1:0] e, g;
        if (rst_n) begin
            g = {m_top, m_mid, m_bot, m_eol, m_eof};
            if (m_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_m_valid got=%h", g);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL column got t/m/b=%h/%h/%h eol=%b eof=%b exp t/m/b=%h/%h/%h eol=%b eof=%b",
                                 g[25:18], g[17:10], g[9:2], g[1], g[0],
                                 e[25:18], e[17:10], e[9:2], e[1], e[0]);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_tests++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL missing_m_valid got=0 exp column %h", e);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && !s_valid) begin
            n_tests++;
            if (fifo0_wr_en || fifo0_rd_en || fifo1_wr_en || fifo1_rd_en) begin
                n_fail++;
                $display("FAIL en_in_gap got=%b%b%b%b exp=0000",
                         fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // mode 0: continuous, 1: alternate 1/0, 2: random gaps
    task automatic drive(input int npix, input int mode, input bit rnd);
        int  sent = 0;
        int  cyc  = 0;
        bit  tog  = 1'b1;
        bit  v, rdy;
        while (sent < npix && cyc < 400) begin
            @(negedge clk);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
            tog = ~tog;
            s_valid = v;
            s_data  = rnd ? DW'($urandom) : DW'((k / W) * 16 + (k % W));
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (v && rdy) begin
                model_push(s_data);
                sent++;
            end
            s_valid = 1'b0;
            cyc++;
        end
        check("drive_timeout", 32'(sent), 32'(npix));
    endtask

    task automatic frame_end_check();
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        #1;
        check("clear_s_ready", 32'(s_ready), 32'd0);
        check("clear_fifo_rst", 32'(fifo_rst), 32'd1);
        check("clear_wr_en", 32'(fifo0_wr_en), 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("idle_after_clear", 32'({s_ready, fifo_rst}), 32'b10);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 32'({m_valid, m_eol, m_eof, fifo_rst, err}), 32'd0);
        check("rst_data", 32'({m_top, m_mid, m_bot}), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        k = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_outputs", 32'({m_valid, m_eol, m_eof, fifo_rst, err}), 32'd0);
        check("init_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        drive(NP, 0, 1'b0);
        frame_end_check();
        drive(NP, 0, 1'b0);
        frame_end_check();
        drive(NP, 1, 1'b0);
        frame_end_check();
        drive(NP, 2, 1'b1);
        frame_end_check();

        drive(10, 2, 1'b1);
        pulse_reset();
        drive(NP, 0, 1'b0);
        frame_end_check();

        drive(1, 0, 1'b0);
        force_full0 = 1'b1;
        drive(1, 0, 1'b0);
        force_full0 = 1'b0;
        check("err_set", 32'(err), 32'(EXP_ERR));
        drive(NP - 2, 0, 1'b0);
        frame_end_check();
        check("err_sticky", 32'(err), 32'(EXP_ERR));
        pulse_reset();
        check("err_after_rst", 32'(err), 32'd0);

        drive(NP, 2, 1'b1);
        frame_end_check();
        check("err_clean_frame", 32'(err), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
